pixel_out_buffer: RTL
=====================

// Module: pixel_out_buffer
// PURPOSE
//  Downstream stage of the SRAM read controller. Accepts its free-running pixel stream
//  (valid, start-of-frame, line-end, 24-bit RGB; no backpressure) into a small FIFO.
//  Re-emits the pixels on a valid/ready interface with SOF/EOL/EOF tags for the display/output sink.
//  Tracks raster position, flags framing errors and overflow, and pulses frame_done on EOF pop.
// PARAMETERS
//  W      256  pixels per line (output image width)
//  H      256  lines per frame
//  DEPTH  16   FIFO entries; power of 2, >=4; AW=$clog2(DEPTH)
// PORTS
//  Clk_in          in   1   clock; all logic on rising edge
//  Reset           in   1   asynchronous, active-high reset
//  in_pixel_valid  in   1   upstream pixel strobe, one pixel per asserted cycle
//  in_frame_start  in   1   qualifies pixel (0,0); meaningful only with in_pixel_valid
//  in_line_end     in   1   qualifies last pixel of a line; meaningful only with in_pixel_valid
//  in_pixel_data   in   24  RGB888 pixel
//  m_valid         out  1   output entry available (FIFO not empty)
//  m_ready         in   1   sink accepts; pop = m_valid & m_ready
//  m_data          out  24  pixel at FIFO head
//  m_sof/m_eol/m_eof out 1  tags of head entry
//  fill_level      out  AW+1 entries currently held, 0..DEPTH
//  frame_done      out  1   one-cycle pulse, cycle after EOF entry is popped
//  overflow        out  1   sticky: a pixel was dropped
//  frame_err       out  1   sticky: framing mismatch (see below)
//  err_clr         in   1   synchronous clear of overflow/frame_err
// BEHAVIOUR
//  Reset: FIFO empty, pointers/counters 0, m_valid=0, m_data=0, all tags 0, fill_level=0,
//   frame_done=0, overflow=0, frame_err=0. Reset mid-frame discards all contents; expected pos -> (0,0).
//  FIFO entry = {eof,eol,sof,data} (27b). eof = in_line_end & (in_row==H-1).
//  Push when in_pixel_valid & (!full | pop). Push+pop same cycle at full: both happen, level unchanged.
//  Push while full without pop: pixel dropped, overflow<=1, write ptr/level unchanged.
//  Pop on empty impossible (m_valid=0); m_ready ignored when empty.
//  Latency: pixel pushed at edge N is visible on m_valid/m_data after edge N (first-word-fall-through,
//   head read combinationally from storage array). m_data/tags hold while m_valid & !m_ready.
//  fill_level = level after each edge; +1 push, -1 pop, 0 both.
//  Position counters in_col (0..W-1), in_row (0..H-1) advance on every in_pixel_valid (dropped or not):
//   col wraps to 0 at W-1 and row increments; row wraps to 0 after (H-1,W-1).
//  frame_err set when, on a valid pixel: in_frame_start != (col==0 & row==0), or
//   in_line_end != (col==W-1). On error counters resync: sof -> pixel treated as (0,0);
//   line_end -> next pixel starts a new line.
//  err_clr clears both sticky flags; a set event in the same cycle wins (flag stays 1).
//  frame_done: registered, asserted the cycle after pop of an entry with eof=1; no other trigger.
//  Pointers AW bits, wrap naturally mod DEPTH; full/empty from separate level counter.
// CONFIGURATION
//  PIX_FRAME_CHECK_EN defined: framing check and counter resync as above.
//  Not defined: frame_err tied 0, no resync; counters still free-run for eof tagging.
//   overflow, err_clr unaffected.
// TESTING
//  1 W=4,H=2,DEPTH=4: 8 valid pixels 0x000001..8 with correct sof/eol, m_ready=1 -> same 8 values out
//    in order, m_sof on 1st, m_eol on 4th/8th, m_eof on 8th, frame_done 1 cycle after 8th pop, errs 0.
//  2 m_ready=0, push 6 pixels into DEPTH=4 -> fill_level=4, overflow=1 after 5th; m_ready=1 ->
//    outputs 0x1..0x4 only; err_clr -> overflow=0.
//  3 Full FIFO, push+pop same cycle -> fill_level stays 4, new pixel enters, overflow stays 0.
//  4 W=4: in_line_end on 3rd pixel of a line -> frame_err=1 (macro on), 0 (macro off); next line aligns.
//  5 Reset asserted mid-frame with 3 entries held -> m_valid=0, fill_level=0 immediately; next pixel with
//    in_frame_start accepted without frame_err.
//  6 err_clr and new framing error in same cycle -> frame_err remains 1.

Source files
------------

// File: rtl/pixel_out_buffer.sv
// Output FIFO between the SRAM read controller and the display sink: FWFT valid/ready
// with SOF/EOL/EOF tags. Optional framing check enabled by `define PIX_FRAME_CHECK_EN.
module pixel_out_buffer #(
   parameter int W     = 256,
   parameter int H     = 256,
   parameter int DEPTH = 16
) (
   input  logic                       Clk_in,
   input  logic                       Reset,
   input  logic                       in_pixel_valid,
   input  logic                       in_frame_start,
   input  logic                       in_line_end,
   input  logic [23:0]                in_pixel_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [23:0]                m_data,
   output logic                       m_sof,
   output logic                       m_eol,
   output logic                       m_eof,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic                       frame_done,
   output logic                       overflow,
   output logic                       frame_err,
   input  logic                       err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam int RW = (H > 1) ? $clog2(H) : 1;
   localparam logic [CW-1:0] LAST_COL = CW'(W - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(H - 1);
   localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

   logic [26:0]   mem [DEPTH];
   logic [26:0]   head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level;
   logic          full, empty, push, pop, drop;

   logic [CW-1:0] col, eff_col, col_nxt;
   logic [RW-1:0] row, eff_row, row_nxt;
   logic          wrap_line, eof_tag, ferr;

   assign full  = (level == FULL_LVL);
   assign empty = (level == '0);
   assign pop   = !empty && m_ready;
   assign push  = in_pixel_valid && (!full || pop);
   assign drop  = in_pixel_valid && full && !pop;

   // Head is read straight from storage; gated so an empty FIFO presents zeros
   assign head       = mem[rd_ptr];
   assign m_valid    = !empty;
   assign m_data     = empty ? 24'd0 : head[23:0];
   assign m_sof      = !empty && head[24];
   assign m_eol      = !empty && head[25];
   assign m_eof      = !empty && head[26];
   assign fill_level = level;

   always_comb begin
      ferr      = 1'b0;
      eff_col   = col;
      eff_row   = row;
      wrap_line = (col == LAST_COL);
`ifdef PIX_FRAME_CHECK_EN
      ferr = in_pixel_valid &&
             ((in_frame_start != ((col == '0) && (row == '0))) ||
              (in_line_end != (col == LAST_COL)));
      // A tagged SOF or EOL is trusted over the counters so one glitch does not poison the frame
      if (in_frame_start) begin
         eff_col = '0;
         eff_row = '0;
      end
      wrap_line = in_line_end || (eff_col == LAST_COL);
`endif
      eof_tag = in_line_end && (eff_row == LAST_ROW);
      if (wrap_line) begin
         col_nxt = '0;
         row_nxt = (eff_row == LAST_ROW) ? '0 : eff_row + RW'(1);
      end else begin
         col_nxt = eff_col + CW'(1);
         row_nxt = eff_row;
      end
   end

   always_ff @(posedge Clk_in) begin
      if (push) mem[wr_ptr] <= {eof_tag, in_line_end, in_frame_start, in_pixel_data};
   end

   always_ff @(posedge Clk_in or posedge Reset) begin
      if (Reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         col        <= '0;
         row        <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + (AW + 1)'(1);
            2'b01:   level <= level - (AW + 1)'(1);
            default: level <= level;
         endcase
         if (in_pixel_valid) begin
            col <= col_nxt;
            row <= row_nxt;
         end
         frame_done <= pop && head[26];
         overflow   <= drop || (overflow && !err_clr);
         frame_err  <= ferr || (frame_err && !err_clr);
      end
   end

endmodule
